// File: rtl/slow_window_ctl.sv
// slow_window_ctl
//
// Watches bus cycles to peripheral chip selects. When a cycle hits a device whose slow enable
// is set, the block runs a request/acknowledge handshake with the clock switcher so the access
// runs at slow timing. Slow mode is held for SlowTimeout prescaler ticks after the last
// qualifying access and is then released.
//
// Ports:
//   CLK, nPOR        clock and synchronous active-low reset
//   BACT             bus cycle active
//   *CS              decoded chip selects (valid while BACT)
//   Slow*            per-device slow enables
//   SlowClockGate    clock-gate enable from settings
//   SlowTimeout[3:0] hold length in ticks
//   Tick             one-cycle prescaler pulse
//   SlowAck          clock switcher reports slow timing in effect
//   SlowReq          request slow timing (registered)
//   Stall            hold current bus cycle (combinational)
//   ClockGate        gate fast clock while slow (registered)
//   Holding          hold counter running (registered)
//
// Optional feature: define SLOW_CLOCKGATE_EN to drive ClockGate; otherwise it is tied low.

module slow_window_ctl (
  input  logic       CLK,
  input  logic       nPOR,
  input  logic       BACT,
  input  logic       IACKCS,
  input  logic       VIACS,
  input  logic       IWMCS,
  input  logic       SCCCS,
  input  logic       SCSICS,
  input  logic       SndCS,
  input  logic       SlowIACK,
  input  logic       SlowVIA,
  input  logic       SlowIWM,
  input  logic       SlowSCC,
  input  logic       SlowSCSI,
  input  logic       SlowSnd,
  input  logic       SlowClockGate,
  input  logic [3:0] SlowTimeout,
  input  logic       Tick,
  input  logic       SlowAck,
  output logic       SlowReq,
  output logic       Stall,
  output logic       ClockGate,
  output logic       Holding
);

  typedef enum logic [2:0] {
    StFast,
    StReq,
    StSlow,
    StHold,
    StRel
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       slow_req_q, slow_req_d;
  logic       clock_gate_q, clock_gate_d;
  logic       holding_q, holding_d;
  logic       qual;

  assign qual = BACT & ((IACKCS & SlowIACK) | (VIACS & SlowVIA) | (IWMCS & SlowIWM) |
                        (SCCCS & SlowSCC) | (SCSICS & SlowSCSI) | (SndCS & SlowSnd));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StFast: if (qual) state_d = StReq;
      StReq:  if (SlowAck) state_d = StSlow;
      StSlow: begin
        if (!BACT) begin
          if (SlowTimeout == 4'd0) begin
            state_d = StRel;
          end else begin
            // Timeout is captured here; later settings writes leave a running hold alone.
            cnt_d   = SlowTimeout;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        // A new qualifying access beats a coincident final tick.
        if (qual) begin
          cnt_d   = 4'd0;
          state_d = StSlow;
        end else if (Tick) begin
          if (cnt_q <= 4'd1) begin
            cnt_d   = 4'd0;
            state_d = StRel;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      StRel:   if (!SlowAck) state_d = StFast;
      default: state_d = StFast;
    endcase
  end

  // Registered outputs follow the next state so they line up with the state register.
  always_comb begin
    slow_req_d = (state_d == StReq) || (state_d == StSlow) || (state_d == StHold);
    holding_d  = (state_d == StHold);
`ifdef SLOW_CLOCKGATE_EN
    clock_gate_d = SlowClockGate & ((state_d == StSlow) || (state_d == StHold));
`else
    clock_gate_d = 1'b0;
`endif
  end

`ifndef SLOW_CLOCKGATE_EN
  logic unused_slow_clock_gate;
  assign unused_slow_clock_gate = SlowClockGate;
`endif

  always_ff @(posedge CLK) begin
    if (!nPOR) begin
      state_q      <= StFast;
      cnt_q        <= 4'd0;
      slow_req_q   <= 1'b0;
      clock_gate_q <= 1'b0;
      holding_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      slow_req_q   <= slow_req_d;
      clock_gate_q <= clock_gate_d;
      holding_q    <= holding_d;
    end
  end

  // Stall only while slow timing is not yet (or no longer) in effect.
  assign Stall = nPOR & qual &
                 ((state_q == StFast) || (state_q == StReq) || (state_q == StRel));

  assign SlowReq   = slow_req_q;
  assign ClockGate = clock_gate_q;
  assign Holding   = holding_q;

endmodule

// File: tb/tb_slow_window_ctl.sv
module tb_slow_window_ctl;

  logic       CLK = 1'b0;
  logic       nPOR, BACT, Tick, SlowAck, SlowClockGate;
  logic       IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS;
  logic       SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd;
  logic [3:0] SlowTimeout;
  logic       SlowReq, Stall, ClockGate, Holding;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  slow_window_ctl dut (
    .CLK(CLK), .nPOR(nPOR), .BACT(BACT),
    .IACKCS(IACKCS), .VIACS(VIACS), .IWMCS(IWMCS), .SCCCS(SCCCS), .SCSICS(SCSICS),
    .SndCS(SndCS),
    .SlowIACK(SlowIACK), .SlowVIA(SlowVIA), .SlowIWM(SlowIWM), .SlowSCC(SlowSCC),
    .SlowSCSI(SlowSCSI), .SlowSnd(SlowSnd),
    .SlowClockGate(SlowClockGate), .SlowTimeout(SlowTimeout), .Tick(Tick),
    .SlowAck(SlowAck),
    .SlowReq(SlowReq), .Stall(Stall), .ClockGate(ClockGate), .Holding(Holding)
  );

  // cs order: {IACK, VIA, IWM, SCC, SCSI, Snd}
  localparam logic [5:0] CsNone = 6'b000000;
  localparam logic [5:0] CsIack = 6'b100000;
  localparam logic [5:0] CsVia  = 6'b010000;
  localparam logic [5:0] CsIwm  = 6'b001000;
  localparam logic [5:0] CsScc  = 6'b000100;
  localparam logic [5:0] CsScsi = 6'b000010;
  localparam logic [5:0] CsSnd  = 6'b000001;

  // One record per cycle: inputs applied during the cycle, outputs expected in that cycle.
  typedef struct packed {
    logic       npor;
    logic       bact;
    logic [5:0] cs;
    logic [3:0] tmo;
    logic       tick;
    logic       ack;
    logic       e_stall;
    logic       e_req;
    logic       e_hold;
    logic       e_cg;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic npor, logic bact, logic [5:0] cs, logic [3:0] tmo,
                              logic tick, logic ack, logic st, logic rq, logic hd, logic cg);
    vec_t v;
    v.npor = npor; v.bact = bact; v.cs = cs; v.tmo = tmo; v.tick = tick; v.ack = ack;
    v.e_stall = st; v.e_req = rq; v.e_hold = hd; v.e_cg = cg;
    return v;
  endfunction

  task automatic drive(logic npor, logic bact, logic [5:0] cs, logic [3:0] tmo, logic tick,
                       logic ack);
    nPOR = npor; BACT = bact; Tick = tick; SlowAck = ack; SlowTimeout = tmo;
    {IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS} = cs;
  endtask

  task automatic check(string name, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_cg(logic cg);
`ifdef SLOW_CLOCKGATE_EN
    return cg;
`else
    return 1'b0 & cg;
`endif
  endfunction

  task automatic step_check(string tag, logic st, logic rq, logic hd, logic cg);
    @(negedge CLK);
    check({tag, ".Stall"}, Stall, st);
    check({tag, ".SlowReq"}, SlowReq, rq);
    check({tag, ".Holding"}, Holding, hd);
    check({tag, ".ClockGate"}, ClockGate, exp_cg(cg));
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int lat;
    // Enables fixed: everything slow except SCC.
    {SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd} = 6'b111011;
    SlowClockGate = 1'b1;
    drive(1'b0, 1'b1, CsVia, 4'd0, 1'b0, 1'b0);
    @(posedge CLK);
    #1;

    //                npor bact cs     tmo  tick ack  stall req hold cg
    // Reset held with a qualifying access present.
    vecs.push_back(mk(1'b0, 1'b1, CsVia, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, CsVia, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, CsVia, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    // VIA access, ack two cycles after SlowReq, 3-tick hold (tick on load cycle ignored).
    vecs.push_back(mk(1'b1, 1'b1, CsVia, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, CsVia, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, CsVia, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, CsVia, 4'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, CsVia, 4'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, CsNone, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, CsNone, 4'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, CsNone, 4'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, CsNone, 4'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, CsNone, 4'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, CsNone, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, CsNone, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, CsNone, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    // SCC access with SlowSCC=0: nothing happens.
    vecs.push_back(mk(1'b1, 1'b1, CsScc, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, CsScc, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, CsNone, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    // SlowTimeout=0, IWM: straight to release, never holding.
    vecs.push_back(mk(1'b1, 1'b1, CsIwm, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, CsIwm, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, CsNone, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, CsNone, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, CsNone, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, CsNone, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    // Cnt=1 hold, qualifying access coincides with final tick: back to SLOW.
    vecs.push_back(mk(1'b1, 1'b1, CsScsi, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, CsScsi, 4'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, CsNone, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, CsScsi, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, CsScsi, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
    // 2-tick hold; non-qualifying SCC access in HOLD does not stop the count.
    vecs.push_back(mk(1'b1, 1'b0, CsNone, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b1, CsScc, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, CsNone, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1));
    // Qual arrives in REL with ack still high: stall through REL, FAST, REQ.
    vecs.push_back(mk(1'b1, 1'b1, CsSnd, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, CsSnd, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, CsSnd, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, CsSnd, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, CsSnd, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, CsSnd, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, CsNone, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 1'b0, CsNone, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, CsNone, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      drive(v.npor, v.bact, v.cs, v.tmo, v.tick, v.ack);
      step_check($sformatf("vec%0d", i), v.e_stall, v.e_req, v.e_hold, v.e_cg);
    end

    // Request latency: IACK access from FAST, SlowReq after exactly one edge (bounded wait).
    drive(1'b1, 1'b1, CsIack, 4'd5, 1'b0, 1'b0);
    lat = 0;
    while (SlowReq !== 1'b1 && lat < 8) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    n_cmp++;
    if (lat != 1) begin
      n_bad++;
      $display("FAIL req_latency: got %0d edges expected 1", lat);
    end
    // Ack, then drop ack while still SLOW: no state change.
    drive(1'b1, 1'b1, CsIack, 4'd5, 1'b0, 1'b1);
    step_check("ackrise", 1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, CsIack, 4'd5, 1'b0, 1'b0);
    step_check("ackdrop0", 1'b0, 1'b1, 1'b0, 1'b1);
    step_check("ackdrop1", 1'b0, 1'b1, 1'b0, 1'b1);
    // Reset mid-handshake: stall forced low, FAST after the edge.
    drive(1'b0, 1'b1, CsIack, 4'd5, 1'b0, 1'b1);
    step_check("midrst", 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, CsIack, 4'd5, 1'b0, 1'b1);
    step_check("postrst", 1'b1, 1'b0, 1'b0, 1'b0);
    step_check("rereq", 1'b1, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
